regfile_param: RTL
==================

Name: regfile_param

Overview:
- Parametrised successor to the core's 32x32 register file.
- Generalised in data width, register count, and read latency (combinational or registered).
- Adds synchronous clear, optional write-to-read bypass, optional hardwired zero register, a configurable watch comparator, a debug read port and a committed-write counter.
- Sits in the datapath between decode (A1/A2/A3) and writeback (WD3/WE3); the watch and debug outputs feed board LEDs and the testbench.

Parameters:
- DATA_W, 32, width of each register and of all data ports
- NUM_REGS, 32, number of architectural registers (2..256)
- ADDR_W, $clog2(NUM_REGS), address width of A1/A2/A3/DBG_ADDR
- READ_LAT, 1, read latency: 0 = combinational read, 1 = registered read
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read port
- ZERO_REG, 1, 1 = register 0 is hardwired to zero
- WATCH_REG, 10, index of the register monitored by watch_hit
- WATCH_VAL, 13, value compared against register WATCH_REG
- CNT_W, 16, width of write_count

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A1  input  ADDR_W  read address, port 1
- A2  input  ADDR_W  read address, port 2
- A3  input  ADDR_W  write address
- WD3  input  DATA_W  write data
- WE3  input  1  write enable
- RD1  output  DATA_W  read data, port 1
- RD2  output  DATA_W  read data, port 2
- DBG_ADDR  input  ADDR_W  debug read address
- dbg_data  output  DATA_W  debug read data (combinational, no bypass)
- watch_hit  output  1  high while register WATCH_REG equals WATCH_VAL (registered)
- write_count  output  CNT_W  number of committed writes since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low. At a posedge with rst_n=0:
  - all registers clear to 0
  - RD1/RD2 (READ_LAT=1) clear to 0
  - watch_hit clears to 0
  - write_count clears to 0
  - WE3 is ignored in that cycle
- Write commit: a write commits at a posedge when rst_n=1, WE3=1, A3<NUM_REGS and not (ZERO_REG=1 and A3=0).
  - Committed write: reg[A3] <= WD3 and write_count increments by 1, wrapping modulo 2^CNT_W.
  - Non-committed writes leave the array and the counter unchanged.
- Read value rv(A), computed per port:
  - 0 if A>=NUM_REGS
  - 0 if ZERO_REG=1 and A=0
  - WD3 if BYPASS=1 and a write commits this cycle with A3=A
  - otherwise reg[A]
- READ_LAT=0: RD1=rv(A1) and RD2=rv(A2), combinational.
- READ_LAT=1: RD1<=rv(A1) and RD2<=rv(A2) at each posedge.
  - Data appears one cycle after the address.
  - With BYPASS=0, a same-cycle write to the read address returns the old value; the new value is visible from the next read onward.
- Simultaneous events:
  - A1=A2=A3 with a commit: both ports see identical data.
  - A write to the zero register alongside a read of it: the read returns 0 regardless of BYPASS.
- dbg_data = reg[DBG_ADDR], combinational, with the same out-of-range and zero-register rules. It never bypasses.
- watch_hit <= (reg[WATCH_REG]==WATCH_VAL) at each posedge, using the array contents before that edge's write.
  - A write of WATCH_VAL at edge k raises watch_hit at edge k+1.
  - A later overwrite with any other value drops it one edge after that write.
  - If WATCH_REG>=NUM_REGS, watch_hit is tied to 0.
- Reset mid-operation: any pending write in the reset cycle is discarded. The first post-reset read of any register returns 0.
- No X propagation: the array is fully reset, so every output is defined from the first post-reset cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with WE3=1, A3=5, WD3=0xDEAD; release and read A1=5 -> RD1=0, write_count=0, watch_hit=0.
- Basic write/read (READ_LAT=1): write A3=3, WD3=0x1234_5678; next cycle A1=3 -> RD1=0x1234_5678 one cycle after the address; write_count=1.
- Bypass: same cycle WE3=1, A3=7, WD3=0xAA, A1=A2=7.
  - BYPASS=1 -> RD1=RD2=0xAA next edge.
  - BYPASS=0 -> old value 0, then 0xAA on the following read.
- Zero register: write A3=0, WD3=0xFFFF_FFFF -> RD1(A1=0)=0, dbg_data(0)=0, write_count unchanged.
- Watch: write reg 10 <= 13 -> watch_hit=1 exactly one edge later; write reg 10 <= 14 -> watch_hit=0 one edge after that write.
- Counter wrap and bounds:
  - With CNT_W=4, 17 committed writes -> write_count=1.
  - With NUM_REGS=16, a write to A3=20 leaves write_count unchanged, and reading A1=20 returns 0.

Source files
------------

// File: rtl/regfile_param.sv
// Purpose : parametrised register file, two read ports, one write port, debug read, watch and write counter.
// Latency : RD1/RD2 combinational (READ_LAT=0) or one clk (READ_LAT=1); dbg_data combinational; watch_hit one clk.
// Backpr. : none; every enabled, in-range, non-zero-register write is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset (clears array, read regs, watch, counter)
//   A1/A2 -> RD1/RD2     read ports (out-of-range and hardwired-zero addresses read 0)
//   A3, WD3, WE3         write port
//   DBG_ADDR -> dbg_data debug read, never bypassed
//   watch_hit            register WATCH_REG equals WATCH_VAL (as of the previous edge)
//   write_count          committed writes since reset, wraps at 2^CNT_W
module regfile_param #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int READ_LAT  = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int WATCH_REG = 10,
  parameter int WATCH_VAL = 13,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  output logic [DATA_W-1:0] dbg_data,
  output logic              watch_hit,
  output logic [CNT_W-1:0]  write_count
);

  // Array index width; A* may be wider than this when the address space
  // deliberately exceeds the register count.
  localparam int                IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0]       NREGS   = NUM_REGS;
  localparam bit                BYP_EN  = (BYPASS != 0);
  localparam bit                ZERO_EN = (ZERO_REG != 0);
  localparam logic [DATA_W-1:0] WATCH_V = DATA_W'(WATCH_VAL);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_val  [2];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == '0);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  // A write only counts when it actually lands in the array; reset masks it.
  assign commit = rst_n && WE3 && in_range(A3) && !is_zero_reg(A3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[to_idx(A3)] <= WD3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) write_count <= '0;
    else if (commit) write_count <= write_count + CNT_W'(1);
  end

  assign rd_addr[0] = A1;
  assign rd_addr[1] = A2;

  // Read value per port. The zero/out-of-range check comes first so a write
  // aimed at the zero register can never leak through the bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      if (in_range(rd_addr[p]) && !is_zero_reg(rd_addr[p])) begin
        if (BYP_EN && commit && (rd_addr[p] == A3)) rd_val[p] = WD3;
        else                                        rd_val[p] = regs[to_idx(rd_addr[p])];
      end
    end
  end

  generate
    if (READ_LAT == 0) begin : g_rd_comb
      assign RD1 = rd_val[0];
      assign RD2 = rd_val[1];
    end else begin : g_rd_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          RD1 <= '0;
          RD2 <= '0;
        end else begin
          RD1 <= rd_val[0];
          RD2 <= rd_val[1];
        end
      end
    end
  endgenerate

  // Debug view shows the stored contents only, never in-flight write data.
  always_comb begin
    dbg_data = '0;
    if (in_range(DBG_ADDR) && !is_zero_reg(DBG_ADDR)) dbg_data = regs[to_idx(DBG_ADDR)];
  end

  // Compares pre-edge contents, so a matching write shows up one edge later.
  generate
    if (WATCH_REG >= 0 && WATCH_REG < NUM_REGS) begin : g_watch
      always_ff @(posedge clk) begin
        if (!rst_n) watch_hit <= 1'b0;
        else        watch_hit <= (regs[WATCH_REG] == WATCH_V);
      end
    end else begin : g_no_watch
      assign watch_hit = 1'b0;
    end
  endgenerate

endmodule
